subword_mem_ctrl: RTL

Multicycle memory-access sequencer between the ARM core's load/store path and a word-only data memory with no byte enables.
- Word accesses pass straight through.
- Byte/halfword loads (LDRB, LDRH, LDRSB, LDRSH) are extracted and extended from the returned word.
- Byte/halfword stores (STRB, STRH) run a read-modify-write.
- Misaligned or reserved-size requests are faulted.
- A stalled memory is faulted by a watchdog.

---
 rtl/subword_mem_ctrl_pkg.sv | 28 ++
 rtl/subword_lane_unit.sv | 58 +++++
 rtl/subword_mem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/subword_mem_ctrl_pkg.sv
// Shared types and constants for the sub-word memory-access sequencer.
// Request sizes, FSM states and the watchdog width live here.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_READ  = 2'b01,
    ST_WRITE = 2'b10,
    ST_RESP  = 2'b11
  } state_t;

  localparam int WATCHDOG_W = 8;

  // Reserved size, odd halfword address, or a word address that is not word aligned.
  function automatic logic is_bad_request(size_t size, logic [1:0] addr_lo);
    return (size == SZ_RSVD) ||
           ((size == SZ_HALF) && addr_lo[0]) ||
           ((size == SZ_WORD) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/subword_lane_unit.sv
// Little-endian lane extraction/extension for loads and lane merge for stores.
// Purely combinational; the sequencer feeds it latched request fields.
module subword_lane_unit
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  size_t              size_e;
  logic        [4:0]  byte_sh;
  logic        [4:0]  half_sh;
  logic        [7:0]  byte_lane;
  logic        [15:0] half_lane;
  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [31:0] byte_ext;
  logic signed [31:0] half_ext;

  assign size_e    = size_t'(size);
  assign byte_sh   = {addr_lo, 3'b000};
  assign half_sh   = {addr_lo[1], 4'b0000};
  assign byte_lane = rdata[byte_sh +: 8];
  assign half_lane = rdata[half_sh +: 16];
  assign byte_s    = byte_lane;
  assign half_s    = half_lane;
  assign byte_ext  = byte_s;
  assign half_ext  = half_s;

  always_comb begin
    load_data   = rdata;
    merged_word = rdata;
    case (size_e)
      SZ_BYTE: begin
        load_data                 = sign_ext ? byte_ext : {24'd0, byte_lane};
        merged_word[byte_sh +: 8] = wdata[7:0];
      end
      SZ_HALF: begin
        load_data                  = sign_ext ? half_ext : {16'd0, half_lane};
        merged_word[half_sh +: 16] = wdata[15:0];
      end
      SZ_WORD: begin
        load_data   = rdata;
        merged_word = wdata;
      end
      default: begin
        load_data   = rdata;
        merged_word = rdata;
      end
    endcase
  end

endmodule

// File: rtl/subword_mem_ctrl.sv
// Multicycle load/store sequencer for a word-only memory without byte enables.
// Sub-word stores run read-modify-write; a watchdog faults a stalled memory.
module subword_mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int unsigned AW          = 32,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [1:0]    req_size,
  input  logic          req_signed,
  input  logic [AW-1:0] req_addr,
  input  logic [31:0]   req_wdata,
  output logic          rsp_valid,
  output logic [31:0]   rsp_rdata,
  output logic          rsp_fault,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [31:0]   mem_wdata,
  input  logic          mem_ack,
  input  logic [31:0]   mem_rdata
);

  state_t                state;
  state_t                state_nxt;
  size_t                 req_size_e;
  size_t                 size_q;
  logic                  sign_q;
  logic [1:0]            addr_lo_q;
  logic                  rmw_q;
  logic [WATCHDOG_W-1:0] wd_cnt;
  logic                  req_fault;
  logic                  accept;
  logic                  wd_expire;
  logic                  phase_entry;
  logic [31:0]           load_data;
  logic [31:0]           merged_word;

  assign req_size_e = size_t'(req_size);
  assign req_fault  = is_bad_request(req_size_e, req_addr[1:0]);
  assign req_ready  = (state == ST_IDLE);
  assign accept     = req_ready && req_valid;
  assign mem_req    = (state == ST_READ) || (state == ST_WRITE);
  assign mem_we     = (state == ST_WRITE);
  assign rsp_valid  = (state == ST_RESP);

  // An ack arriving in the expiry cycle takes priority over the timeout.
  assign wd_expire = (TIMEOUT_CYC != 0) && mem_req && !mem_ack &&
                     ((32'(wd_cnt) + 32'd1) == TIMEOUT_CYC);

  assign phase_entry = (state_nxt != state) &&
                       ((state_nxt == ST_READ) || (state_nxt == ST_WRITE));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (req_fault)
            state_nxt = ST_RESP;
          else if (req_write && (req_size_e == SZ_WORD))
            state_nxt = ST_WRITE;
          else
            state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (mem_ack)
          state_nxt = rmw_q ? ST_WRITE : ST_RESP;
        else if (wd_expire)
          state_nxt = ST_RESP;
      end
      ST_WRITE: begin
        if (mem_ack || wd_expire)
          state_nxt = ST_RESP;
      end
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      state <= ST_IDLE;
    else
      state <= state_nxt;
  end

  // mem_wdata doubles as the store-data holding register until the RMW merge replaces it.
  subword_lane_unit u_lane (
    .size        (size_q),
    .sign_ext    (sign_q),
    .addr_lo     (addr_lo_q),
    .rdata       (mem_rdata),
    .wdata       (mem_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      size_q    <= SZ_BYTE;
      sign_q    <= 1'b0;
      addr_lo_q <= 2'b00;
      rmw_q     <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      wd_cnt    <= '0;
    end else begin
      if (accept) begin
        size_q    <= req_size_e;
        sign_q    <= req_signed;
        addr_lo_q <= req_addr[1:0];
        rmw_q     <= req_write && (req_size_e != SZ_WORD);
        mem_addr  <= {req_addr[AW-1:2], 2'b00};
        mem_wdata <= req_wdata;
        rsp_rdata <= '0;
        rsp_fault <= req_fault;
      end
      if ((state == ST_READ) && mem_ack) begin
        if (rmw_q)
          mem_wdata <= merged_word;
        else
          rsp_rdata <= load_data;
      end
      if (wd_expire)
        rsp_fault <= 1'b1;
      if (phase_entry)
        wd_cnt <= '0;
      else if (mem_req && !mem_ack)
        wd_cnt <= wd_cnt + 1'b1;
    end
  end

endmodule
